// File: rtl/key_pkg.sv
// Shared definitions for the key event front end: channel state encoding,
// default cycle constants for a 50 MHz clock and a small elaboration helper.
package key_pkg;

  // Per-channel debounce / hold state, 3-bit encoding.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    PRESSED    = 3'd2,
    LONG       = 3'd3,
    RELEASE_DB = 3'd4
  } key_state_e;

  // Default timing at 50 MHz.
  localparam int unsigned DEF_N_KEY        = 4;
  localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;   // 20 ms
  localparam int unsigned DEF_LONG_CYC     = 50_000_000;  // 1 s
  localparam int unsigned DEF_REPEAT_CYC   = 10_000_000;  // 200 ms

  // Larger of two elaboration-time constants, used to size the hold counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_event_ch.sv
// One key channel: 2-FF synchronizer, debounce counter, hold counter and the
// IDLE/PRESS_DB/PRESSED/LONG/RELEASE_DB state machine. All outputs are
// registered. Optional auto-repeat of long_press is built only when the
// KEY_REPEAT_EN macro is defined.
module key_event_ch
  import key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_key,
  output logic o_fs,
  output logic o_press,
  output logic o_release,
  output logic o_long_press
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(max_u(LONG_CYC, REPEAT_CYC) + 1);

  // Terminal counts: a counter value of N-1 on entry means N stable cycles.
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYC - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_CYC - 1);
`endif

  // Synchronizer and state registers
  logic              r_sync1;
  logic              r_sync2;
  key_state_e        r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_origin_long;  // RELEASE_DB was entered from LONG
  logic              r_fs;
  logic              r_press;
  logic              r_release;
  logic              r_long_press;

  // Next-state values
  logic              w_raw_p;
  key_state_e        w_state_nxt;
  logic [DB_W-1:0]   w_db_nxt;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_origin_nxt;
  logic              w_press_nxt;
  logic              w_release_nxt;
  logic              w_long_nxt;
  logic              w_fs_nxt;
  logic [DB_W-1:0]   w_db_inc;
  logic [HOLD_W-1:0] w_hold_inc;

  // Bring the asynchronous pin into the clock domain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the synchronizer resets to the released level (1) so a key that
      // is held through reset is seen as a fresh falling edge afterwards.
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make r_sync2 take the *old* r_sync1,
      // giving two real flop stages; blocking here would collapse them.
      r_sync1 <= i_key;
      r_sync2 <= r_sync1;
    end
  end

  // Pins are active-low; everything downstream works on "pressed = 1".
  assign w_raw_p = ~r_sync2;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign w_db_inc   = (&r_db_cnt)   ? r_db_cnt   : r_db_cnt + DB_W'(1);
  assign w_hold_inc = (&r_hold_cnt) ? r_hold_cnt : r_hold_cnt + HOLD_W'(1);

  // fs follows the accepted level one cycle after the accepting pulse.
  assign w_fs_nxt = (r_state == PRESSED) || (r_state == LONG) ||
                    (r_state == RELEASE_DB);

  // Channel state machine: next state, counters and one-cycle pulses.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    w_state_nxt   = r_state;
    w_db_nxt      = r_db_cnt;
    w_hold_nxt    = r_hold_cnt;
    w_origin_nxt  = r_origin_long;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_raw_p) begin
          w_state_nxt = PRESS_DB;
          w_db_nxt    = '0;
        end
      end

      PRESS_DB: begin
        if (!w_raw_p) begin
          w_state_nxt = IDLE;
        end else if (r_db_cnt >= DB_LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_db_nxt = w_db_inc;
        end
      end

      PRESSED: begin
        // Every cycle spent here counts towards the hold time, including
        // the one in which the key starts to bounce away.
        w_hold_nxt = w_hold_inc;
        if (!w_raw_p) begin
          w_state_nxt  = RELEASE_DB;
          w_db_nxt     = '0;
          w_origin_nxt = 1'b0;
        end else if (r_hold_cnt >= LONG_LAST) begin
          w_state_nxt = LONG;
          w_long_nxt  = 1'b1;
`ifdef KEY_REPEAT_EN
          w_hold_nxt  = '0;
`endif
        end
      end

      LONG: begin
`ifdef KEY_REPEAT_EN
        w_hold_nxt = w_hold_inc;
`endif
        if (!w_raw_p) begin
          w_state_nxt  = RELEASE_DB;
          w_db_nxt     = '0;
          w_origin_nxt = 1'b1;
        end
`ifdef KEY_REPEAT_EN
        else if (r_hold_cnt >= REPEAT_LAST) begin
          w_long_nxt = 1'b1;
          w_hold_nxt = '0;
        end
`endif
      end

      RELEASE_DB: begin
        // hold_cnt is left untouched here, so a bounce back resumes it.
        if (w_raw_p) begin
          w_state_nxt = r_origin_long ? LONG : PRESSED;
        end else if (r_db_cnt >= DB_LAST) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_db_nxt = w_db_inc;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Register the state machine, counters and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_db_cnt      <= '0;
      r_hold_cnt    <= '0;
      r_origin_long <= 1'b0;
      r_fs          <= 1'b0;
      r_press       <= 1'b0;
      r_release     <= 1'b0;
      r_long_press  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_db_cnt      <= w_db_nxt;
      r_hold_cnt    <= w_hold_nxt;
      r_origin_long <= w_origin_nxt;
      r_fs          <= w_fs_nxt;
      r_press       <= w_press_nxt;
      r_release     <= w_release_nxt;
      r_long_press  <= w_long_nxt;
    end
  end

  assign o_fs         = r_fs;
  assign o_press      = r_press;
  assign o_release    = r_release;
  assign o_long_press = r_long_press;

endmodule

// File: rtl/key_event.sv
// Multi-channel key front end: N_KEY independent copies of key_event_ch turn
// raw active-low, bouncy pins into a debounced level plus press, release and
// long-press pulses. Define KEY_REPEAT_EN to make long_press auto-repeat
// every REPEAT_CYC cycles while the key stays held.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned N_KEY        = DEF_N_KEY,
  parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
  parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_KEY-1:0] i_key,
  output logic [N_KEY-1:0] o_fs,
  output logic [N_KEY-1:0] o_press,
  output logic [N_KEY-1:0] o_release,
  output logic [N_KEY-1:0] o_long_press
);

  // One fully independent channel per key pin.
  for (genvar g = 0; g < N_KEY; g++) begin : g_ch
    key_event_ch #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC),
      .REPEAT_CYC   (REPEAT_CYC)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_key        (i_key[g]),
      .o_fs         (o_fs[g]),
      .o_press      (o_press[g]),
      .o_release    (o_release[g]),
      .o_long_press (o_long_press[g])
    );
  end

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event with DEBOUNCE_CYC=8, LONG_CYC=32,
// REPEAT_CYC=16. A run-length model of the key rules predicts every output
// each cycle; directed scenarios add literal latency/count expectations.
module tb_key_event;

  localparam int N = 4;
  localparam int D = 8;
  localparam int L = 32;
  localparam int R = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] i_key = '1;
  logic [N-1:0] o_fs, o_press, o_release, o_long_press;

  key_event #(
    .N_KEY        (N),
    .DEBOUNCE_CYC (D),
    .LONG_CYC     (L),
    .REPEAT_CYC   (R)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_key        (i_key),
    .o_fs         (o_fs),
    .o_press      (o_press),
    .o_release    (o_release),
    .o_long_press (o_long_press)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;   // index of the most recent rising edge
  bit chk_en   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pins seen through two sample delays; a level change is accepted after
  // D+1 consecutive disagreeing samples. Hold time counts cycles the key is
  // accepted-pressed and not in the middle of a release debounce.
  logic [N-1:0] m_s1 = '1, m_s2 = '1;
  logic [N-1:0] m_lvl = '0;
  int           m_run[N];
  int           m_held[N];
  int           m_rep[N];
  bit           m_ldone[N];
  logic [N-1:0] e_fs = '0, e_press = '0, e_rel = '0, e_long = '0;

  task automatic model_step();
    logic raw, lvl_before;
    int   run_before;
    if (!rst_n) begin
      m_s1 = '1; m_s2 = '1; m_lvl = '0;
      e_fs = '0; e_press = '0; e_rel = '0; e_long = '0;
      for (int k = 0; k < N; k++) begin
        m_run[k] = 0; m_held[k] = 0; m_rep[k] = 0; m_ldone[k] = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        raw        = ~m_s2[k];
        lvl_before = m_lvl[k];
        run_before = m_run[k];
        e_fs[k]    = lvl_before;
        e_press[k] = 1'b0;
        e_rel[k]   = 1'b0;
        e_long[k]  = 1'b0;
        if (raw != lvl_before) begin
          m_run[k]++;
          if (m_run[k] == D + 1) begin
            m_lvl[k] = raw;
            m_run[k] = 0;
            if (raw) begin
              e_press[k] = 1'b1;
              m_held[k] = 0; m_ldone[k] = 0; m_rep[k] = 0;
            end else begin
              e_rel[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
        if (lvl_before && run_before == 0) begin
          if (!m_ldone[k]) begin
            if (raw && m_held[k] >= L - 1) begin
              e_long[k] = 1'b1; m_ldone[k] = 1; m_rep[k] = 0;
            end else begin
              m_held[k]++;
            end
          end
`ifdef KEY_REPEAT_EN
          else if (raw && m_rep[k] >= R - 1) begin
            e_long[k] = 1'b1; m_rep[k] = 0;
          end else begin
            m_rep[k]++;
          end
`endif
        end
      end
      m_s2 = m_s1;
      m_s1 = i_key;
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_held[k] = 0; m_rep[k] = 0; m_ldone[k] = 0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  // ---------------- compare + event log ----------------
  int           press_at[N], rel_at[N], long_at[N], fs_at[N];
  int           press_cnt[N], rel_cnt[N], long_cnt[N];
  logic [N-1:0] last_fs = '0;

  initial begin
    for (int k = 0; k < N; k++) begin
      press_at[k] = -1000; rel_at[k] = -1000; long_at[k] = -1000; fs_at[k] = -1000;
      press_cnt[k] = 0; rel_cnt[k] = 0; long_cnt[k] = 0;
    end
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("fs",         32'(o_fs),         32'(e_fs));
        check("press",      32'(o_press),      32'(e_press));
        check("release",    32'(o_release),    32'(e_rel));
        check("long_press", 32'(o_long_press), 32'(e_long));
        for (int k = 0; k < N; k++) begin
          if (o_press[k] === 1'b1)      begin press_at[k] = cyc; press_cnt[k]++; end
          if (o_release[k] === 1'b1)    begin rel_at[k]   = cyc; rel_cnt[k]++;   end
          if (o_long_press[k] === 1'b1) begin long_at[k]  = cyc; long_cnt[k]++;  end
          if (o_fs[k] === 1'b1 && last_fs[k] !== 1'b1) fs_at[k] = cyc;
        end
        last_fs = o_fs;
      end
    end
  end

  // Advance n rising edges, then step 2 time units past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int t0, t1, tr, pc, rc, lc;

    rst_n = 1'b0;
    i_key = '1;
    tick(3);
    chk_en = 1;
    check("reset_outputs", 32'({o_fs, o_press, o_release, o_long_press}), 32'h0);
    rst_n = 1'b1;
    tick(5);

    // Clean press of key[0], held 20 cycles.
    i_key[0] = 1'b0; t0 = cyc + 1;
    tick(20);
    i_key[0] = 1'b1; t1 = cyc + 1;
    tick(20);
    check("t1_press_latency",   32'(press_at[0] - t0), 32'd10);
    check("t1_fs_latency",      32'(fs_at[0] - t0),    32'd11);
    check("t1_release_latency", 32'(rel_at[0] - t1),   32'd10);
    check("t1_no_long",         32'(long_cnt[0]),      32'd0);

    // key[1] bounces every 3 cycles, then settles low.
    for (int i = 0; i < 5; i++) begin
      i_key[1] = 1'b0; tick(3);
      i_key[1] = 1'b1; tick(3);
    end
    check("t2_no_bounce_press", 32'(press_cnt[1]), 32'd0);
    i_key[1] = 1'b0; t0 = cyc + 1;
    tick(25);
    check("t2_single_press",  32'(press_cnt[1]),      32'd1);
    check("t2_press_latency", 32'(press_at[1] - t0),  32'd10);
    i_key[1] = 1'b1;
    tick(20);
    check("t2_release_count", 32'(rel_cnt[1]), 32'd1);

    // key[2] held 50 cycles -> one long press 32 cycles after the press.
    i_key[2] = 1'b0; t0 = cyc + 1;
    tick(50);
    i_key[2] = 1'b1;
    tick(20);
    check("t3_press_latency", 32'(press_at[2] - t0),          32'd10);
    check("t3_long_delay",    32'(long_at[2] - press_at[2]),  32'd32);
    check("t3_long_once",     32'(long_cnt[2]),               32'd1);
    check("t3_release_count", 32'(rel_cnt[2]),                32'd1);

    // key[0] and key[3] pressed in the same cycle.
    i_key = 4'b0110; t0 = cyc + 1;
    tick(11);
    check("t4_dual_press", 32'(o_press), 32'h9);
    tick(5);
    i_key = '1;
    tick(20);

    // Held key[2] with a 4-cycle high glitch: no release, long delayed by 4.
    rc = rel_cnt[2]; lc = long_cnt[2];
    i_key[2] = 1'b0; t0 = cyc + 1;
    tick(20);
    i_key[2] = 1'b1;
    tick(4);
    i_key[2] = 1'b0;
    tick(40);
    check("t5_no_release",  32'(rel_cnt[2] - rc),  32'd0);
    check("t5_long_timing", 32'(long_at[2] - t0),  32'd46);
    check("t5_long_once",   32'(long_cnt[2] - lc), 32'd1);
    i_key[2] = 1'b1;
    tick(20);

    // Reset for 2 cycles while key[0] is held, key still low afterwards.
    i_key[0] = 1'b0;
    tick(20);
    pc = press_cnt[0]; rc = rel_cnt[0];
    rst_n = 1'b0;
    tick(1);
    check("t6_reset_outputs_a", 32'({o_fs, o_press, o_release, o_long_press}), 32'h0);
    tick(1);
    check("t6_reset_outputs_b", 32'({o_fs, o_press, o_release, o_long_press}), 32'h0);
    rst_n = 1'b1; tr = cyc + 1;
    tick(20);
    check("t6_press_latency", 32'(press_at[0] - tr),   32'd10);
    check("t6_new_press",     32'(press_cnt[0] - pc),  32'd1);
    check("t6_no_release",    32'(rel_cnt[0] - rc),    32'd0);
    i_key[0] = 1'b1;
    tick(20);
    check("t6_release_after", 32'(rel_cnt[0] - rc),    32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
